// File: rtl/minivan_pkg.sv
// minivan_pkg: shared constants and state type for the minivan SPI register-bus bridge
package minivan_pkg;
  localparam int SPI_CMD_WR_BIT = 7;
  localparam int SPI_FETCH_WAIT = 2;
  typedef enum logic [2:0] {IDLE, CMD, FETCH, DATA, WRITE, NEXT} spi_rb_state_t;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer for an asynchronous SPI pin, with rise/fall pulses
// Ports: clk, resetb (sync, active-low; clears to RST_VAL), i_d async pin,
//        o_q synced level, o_rise/o_fall one-clk pulses from the last two synced samples.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetb,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta, r_sync, r_prev;
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end
  assign o_q    = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/spi_rb_bridge.sv
// spi_rb_bridge: SPI mode-0 slave turning host frames into minivan register-bus accesses
// Ports: clk, resetb (sync, active-low); spi_csn/spi_sck/spi_mosi/spi_miso host pins,
//        oversampled on clk (clk >= 16x spi_sck); address/data_write_in/write_en/reg_en
//        drive the bank, data_read_out is the bank's registered read data.
// Build option: define SPI_RB_AUTOINC_EN to step the address after every data byte.
module spi_rb_bridge
  import minivan_pkg::*;
#(
  parameter int ADR_BITS = 8
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                spi_csn,
  input  logic                spi_sck,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic [ADR_BITS-1:0] address,
  output logic [7:0]          data_write_in,
  input  logic [7:0]          data_read_out,
  output logic                reg_en,
  output logic                write_en
);
  spi_rb_state_t r_state, w_nxt;
  logic w_csn_q, w_csn_rise, w_csn_fall, w_sck_q, w_sck_rise, w_sck_fall;
  logic r_mosi_meta, r_mosi, r_wr, r_reg_en, r_armed;
  logic w_last, w_cmd_done, w_fetch_done;
  logic [6:0] r_sin;
  logic [7:0] r_sout, r_dwi, w_byte;
  logic [2:0] r_cnt;
  logic [1:0] r_wait, r_settle;
  logic [ADR_BITS-1:0] r_addr;

  spi_sync #(.RST_VAL(1'b1)) u_csn (
    .clk(clk), .resetb(resetb), .i_d(spi_csn),
    .o_q(w_csn_q), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .resetb(resetb), .i_d(spi_sck),
    .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  always_comb begin
    w_byte       = {r_sin, r_mosi};
    w_last       = w_sck_rise && r_cnt == 3'd7;
    w_cmd_done   = r_state == CMD && w_last && !w_csn_q;
    w_fetch_done = r_state == FETCH && r_wait == 2'(SPI_FETCH_WAIT - 1);
    w_nxt        = r_state;
    case (r_state)
      IDLE:    w_nxt = r_armed && w_csn_fall && !w_sck_q ? CMD : IDLE;
      CMD:     w_nxt = w_csn_q ? IDLE : w_cmd_done ? (w_byte[SPI_CMD_WR_BIT] ? DATA : FETCH) : CMD;
      FETCH:   w_nxt = w_csn_q ? IDLE : w_fetch_done ? DATA : FETCH;
      // the 8th data rise beats a simultaneous csn rise so the write still lands
      DATA:    w_nxt = w_last ? (r_wr ? WRITE : NEXT) : w_csn_q ? IDLE : DATA;
      WRITE:   w_nxt = NEXT;
      NEXT:    w_nxt = w_csn_q ? IDLE : r_wr ? DATA : FETCH;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) r_state <= !resetb ? IDLE : w_nxt;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_mosi_meta <= 1'b0;
      r_mosi      <= 1'b0;
      r_wr        <= 1'b0;
      r_reg_en    <= 1'b0;
      r_armed     <= 1'b0;
      r_sin       <= '0;
      r_sout      <= '0;
      r_dwi       <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_settle    <= '0;
      r_addr      <= '0;
    end else begin
      r_mosi_meta <= spi_mosi;
      r_mosi      <= r_mosi_meta;
      // a frame is accepted only after csn has been seen high since reset
      r_settle    <= r_settle + 2'(r_settle != 2'd3);
      r_armed     <= r_armed || w_csn_rise || (r_settle == 2'd3 && w_csn_q);
      r_reg_en    <= w_nxt != IDLE && w_nxt != CMD;
      r_cnt       <= r_state == IDLE ? 3'd0 : r_cnt + 3'(w_sck_rise);
      r_wait      <= r_state == FETCH ? r_wait + 2'd1 : 2'd0;
      if (w_sck_rise) r_sin <= w_byte[6:0];
      if (w_cmd_done) begin
        r_addr <= ADR_BITS'(w_byte[6:0]);
        r_wr   <= w_byte[SPI_CMD_WR_BIT];
      end
`ifdef SPI_RB_AUTOINC_EN
      else if (r_state == NEXT && !w_csn_q) r_addr <= r_addr + ADR_BITS'(1);
`endif
      // the fall that ends the previous byte arrives with r_cnt==0 and must not shift
      if (w_fetch_done) r_sout <= data_read_out;
      else if (r_state == DATA && w_sck_fall && r_cnt != 3'd0) r_sout <= {r_sout[6:0], 1'b0};
      if (r_state == DATA && w_last && r_wr) r_dwi <= w_byte;
    end
  end

  assign spi_miso      = r_state == DATA && !r_wr && r_sout[7];
  assign address       = r_addr;
  assign data_write_in = r_dwi;
  assign reg_en        = r_reg_en;
  assign write_en      = r_state == WRITE;
endmodule

// File: tb/tb_spi_rb_bridge.sv
// tb_spi_rb_bridge: directed self-checking bench for spi_rb_bridge with a small register bank model
module tb_spi_rb_bridge;
  localparam int HALF = 100;
  logic clk = 1'b0, resetb = 1'b0, spi_csn = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, reg_en, write_en;
  logic [7:0] address, data_write_in, data_read_out;
  logic [7:0] mem [256];
  logic [7:0] wr_a [16];
  logic [7:0] wr_d [16];
  int checks = 0, errors = 0, wr_n = 0;
`ifdef SPI_RB_AUTOINC_EN
  int inc = 1;
`else
  int inc = 0;
`endif

  always #5 clk = ~clk;

  spi_rb_bridge #(.ADR_BITS(8)) dut (
    .clk(clk), .resetb(resetb), .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .address(address), .data_write_in(data_write_in),
    .data_read_out(data_read_out), .reg_en(reg_en), .write_en(write_en)
  );

  always @(posedge clk) begin
    if (!resetb) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 3) ? 8'h11 : 8'h00;
      data_read_out <= 8'h00;
    end else begin
      if (write_en) mem[address] <= data_write_in;
      data_read_out <= mem[address];
    end
  end

  always @(negedge clk) begin
    if (resetb && write_en) begin
      if (wr_n < 16) begin
        wr_a[wr_n] <= address;
        wr_d[wr_n] <= data_write_in;
      end
      wr_n <= wr_n + 1;
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, input bit cs_last, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      #HALF;
      spi_sck = 1'b1;
      if (cs_last && i == n - 1) spi_csn = 1'b1;
      rx[7-i] = spi_miso;
      #HALF;
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame_start;
    @(negedge clk);
    spi_csn = 1'b0;
    #HALF;
  endtask

  task automatic frame_stop;
    #HALF;
    spi_csn = 1'b1;
    #(4*HALF);
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({spi_miso, reg_en, write_en, address, data_write_in} !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h want 0", i, {spi_miso, reg_en, write_en, address, data_write_in});
      end
    end
    checks++;
    if (wr_n !== 0) begin errors++; $display("FAIL reset_no_write got %0d want 0", wr_n); end
  endtask

  task automatic test_write;
    int n0;
    logic [7:0] r;
    n0 = wr_n;
    frame_start;
    spi_bits(8'h92, 8, 1'b0, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL write_cmd_miso got %h want 00", r); end
    spi_bits(8'h40, 8, 1'b0, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL write_data_miso got %h want 00", r); end
    frame_stop;
    checks++;
    if (wr_n !== n0 + 1) begin errors++; $display("FAIL write_count got %0d want %0d", wr_n - n0, 1); end
    checks++;
    if (wr_a[n0] !== 8'd18) begin errors++; $display("FAIL write_addr got %0d want 18", wr_a[n0]); end
    checks++;
    if (wr_d[n0] !== 8'h40) begin errors++; $display("FAIL write_data got %h want 40", wr_d[n0]); end
    frame_start;
    spi_bits(8'h12, 8, 1'b0, r);
    spi_bits(8'h00, 8, 1'b0, r);
    frame_stop;
    checks++;
    if (r !== 8'h40) begin errors++; $display("FAIL write_readback got %h want 40", r); end
    checks++;
    if (wr_n !== n0 + 1) begin errors++; $display("FAIL readback_no_write got %0d want %0d", wr_n, n0 + 1); end
  endtask

  task automatic test_read;
    int n0;
    logic [7:0] r;
    n0 = wr_n;
    frame_start;
    spi_bits(8'h03, 8, 1'b0, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL read_cmd_miso got %h want 00", r); end
    spi_bits(8'h00, 8, 1'b0, r);
    checks++;
    if (r !== 8'h11) begin errors++; $display("FAIL read_data got %h want 11", r); end
    #HALF;
    checks++;
    if (reg_en !== 1'b1) begin errors++; $display("FAIL read_reg_en_active got %b want 1", reg_en); end
    spi_csn = 1'b1;
    #(4*HALF);
    checks++;
    if (reg_en !== 1'b0) begin errors++; $display("FAIL read_reg_en_idle got %b want 0", reg_en); end
    checks++;
    if (wr_n !== n0) begin errors++; $display("FAIL read_no_write got %0d want %0d", wr_n, n0); end
  endtask

  task automatic test_burst;
    int n0;
    logic [7:0] r;
    n0 = wr_n;
    frame_start;
    spi_bits(8'h92, 8, 1'b0, r);
    for (int k = 1; k <= 3; k++) spi_bits(8'(k), 8, 1'b0, r);
    frame_stop;
    checks++;
    if (wr_n !== n0 + 3) begin errors++; $display("FAIL burst_count got %0d want 3", wr_n - n0); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (wr_a[n0+k] !== 8'(18 + inc * k)) begin
        errors++;
        $display("FAIL burst_addr %0d got %0d want %0d", k, wr_a[n0+k], 18 + inc * k);
      end
      checks++;
      if (wr_d[n0+k] !== 8'(k + 1)) begin
        errors++;
        $display("FAIL burst_data %0d got %h want %h", k, wr_d[n0+k], k + 1);
      end
    end
    frame_start;
    spi_bits(8'h12, 8, 1'b0, r);
    for (int k = 0; k < (inc == 1 ? 3 : 1); k++) begin
      spi_bits(8'h00, 8, 1'b0, r);
      checks++;
      if (r !== (inc == 1 ? 8'(k + 1) : 8'h03)) begin
        errors++;
        $display("FAIL burst_readback %0d got %h want %h", k, r, inc == 1 ? k + 1 : 3);
      end
    end
    frame_stop;
  endtask

  task automatic test_abort;
    int n0;
    logic [7:0] r;
    n0 = wr_n;
    frame_start;
    spi_bits(8'h85, 8, 1'b0, r);
    spi_bits(8'hA0, 4, 1'b0, r);
    checks++;
    if (reg_en !== 1'b1) begin errors++; $display("FAIL abort_reg_en_before got %b want 1", reg_en); end
    @(negedge clk);
    spi_csn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (reg_en !== 1'b0) begin errors++; $display("FAIL abort_reg_en_drop got %b want 0", reg_en); end
    checks++;
    if (address !== 8'd5) begin errors++; $display("FAIL abort_addr_hold got %0d want 5", address); end
    #(4*HALF);
    checks++;
    if (wr_n !== n0) begin errors++; $display("FAIL abort_no_write got %0d want %0d", wr_n, n0); end
    frame_start;
    spi_bits(8'h86, 8, 1'b0, r);
    spi_bits(8'h5A, 8, 1'b0, r);
    frame_stop;
    checks++;
    if (wr_n !== n0 + 1) begin errors++; $display("FAIL after_abort_count got %0d want 1", wr_n - n0); end
    checks++;
    if (wr_a[n0] !== 8'd6 || wr_d[n0] !== 8'h5A) begin
      errors++;
      $display("FAIL after_abort_write got %0d/%h want 6/5a", wr_a[n0], wr_d[n0]);
    end
  endtask

  task automatic test_coincident;
    int n0;
    logic [7:0] r;
    n0 = wr_n;
    frame_start;
    spi_bits(8'h8A, 8, 1'b0, r);
    spi_bits(8'hC3, 8, 1'b1, r);
    #(4*HALF);
    checks++;
    if (wr_n !== n0 + 1) begin errors++; $display("FAIL coincident_count got %0d want 1", wr_n - n0); end
    checks++;
    if (wr_a[n0] !== 8'd10 || wr_d[n0] !== 8'hC3) begin
      errors++;
      $display("FAIL coincident_write got %0d/%h want 10/c3", wr_a[n0], wr_d[n0]);
    end
    checks++;
    if (reg_en !== 1'b0) begin errors++; $display("FAIL coincident_idle got %b want 0", reg_en); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r;
    frame_start;
    spi_bits(8'h03, 8, 1'b0, r);
    spi_bits(8'h00, 4, 1'b0, r);
    checks++;
    if (reg_en !== 1'b1 || address !== 8'd3) begin
      errors++;
      $display("FAIL midreset_before got %b/%0d want 1/3", reg_en, address);
    end
    @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    checks++;
    if ({spi_miso, reg_en, write_en, address, data_write_in} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0", {spi_miso, reg_en, write_en, address, data_write_in});
    end
    resetb = 1'b1;
    repeat (10) @(negedge clk);
    spi_csn = 1'b1;
    #(4*HALF);
    frame_start;
    spi_bits(8'h03, 8, 1'b0, r);
    spi_bits(8'h00, 8, 1'b0, r);
    frame_stop;
    checks++;
    if (r !== 8'h11) begin errors++; $display("FAIL midreset_reread got %h want 11", r); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_burst;
    test_abort;
    test_coincident;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
